// File: rtl/game_ctrl_if.sv
// Control bus for game_ctrl: raw buttons, frame timing and collision in; game state out.
interface game_ctrl_if;
    logic       BtnU;
    logic       BtnD;
    logic       BtnL;
    logic       BtnR;
    logic       frame_tick;
    logic       collision;
    logic [1:0] state;
    logic [9:0] pos_x;
    logic [9:0] pos_y;
    logic [13:0] score;
    logic [1:0] lives;

    modport master (
        output BtnU, BtnD, BtnL, BtnR, frame_tick, collision,
        input  state, pos_x, pos_y, score, lives
    );

    modport slave (
        input  BtnU, BtnD, BtnL, BtnR, frame_tick, collision,
        output state, pos_x, pos_y, score, lives
    );
endinterface

// File: rtl/game_ctrl.sv
// Game controller: synchronised, debounced buttons drive a four-state game FSM that moves the
// player per frame inside a clamped box, keeps score and lives, and handles hit/game-over.
module game_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned STEP            = 4,
    parameter int unsigned X_MIN           = 144,
    parameter int unsigned X_MAX           = 783,
    parameter int unsigned Y_MIN           = 35,
    parameter int unsigned Y_MAX           = 514,
    parameter int unsigned X_START         = 464,
    parameter int unsigned Y_START         = 275,
    parameter int unsigned HIT_FRAMES      = 60
) (
    input  logic        ClkPort,
    input  logic        BtnC,
    game_ctrl_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StPlay = 2'd1,
        StHit  = 2'd2,
        StOver = 2'd3
    } state_t;

    // Button index: 0=U, 1=D, 2=L, 3=R
    logic [3:0]       raw;
    logic [3:0]       sync1;
    logic [3:0]       sync2;
    logic [3:0]       level;
    logic [3:0]       press;
    logic [CNT_W-1:0] cnt [4];

    assign raw = {bus.BtnR, bus.BtnL, bus.BtnD, bus.BtnU};

    always_ff @(posedge ClkPort or posedge BtnC) begin
        if (BtnC) begin
            sync1 <= '0;
            sync2 <= '0;
            level <= '0;
            press <= '0;
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            press <= '0;
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] != level[i]) begin
                    if (cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                        level[i] <= sync2[i];
                        press[i] <= sync2[i];
                        cnt[i]   <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + 1'b1;
                    end
                end else begin
                    cnt[i] <= '0;
                end
            end
        end
    end

    state_t      state;
    logic [9:0]  pos_x;
    logic [9:0]  pos_y;
    logic [13:0] score;
    logic [1:0]  lives;
    logic [15:0] hit_cnt;

    logic [9:0]  next_x;
    logic [9:0]  next_y;
    logic [13:0] next_score;
    logic [31:0] x_ext;
    logic [31:0] y_ext;

    // Clamp in 32 bits so neither direction can wrap the 10-bit coordinate.
    always_comb begin
        x_ext  = {22'd0, pos_x};
        y_ext  = {22'd0, pos_y};
        next_x = pos_x;
        next_y = pos_y;
        if (level[3] && !level[2]) begin
            next_x = (x_ext + STEP > X_MAX) ? 10'(X_MAX) : 10'(x_ext + STEP);
        end else if (level[2] && !level[3]) begin
            next_x = (x_ext < X_MIN + STEP) ? 10'(X_MIN) : 10'(x_ext - STEP);
        end
        if (level[1] && !level[0]) begin
            next_y = (y_ext + STEP > Y_MAX) ? 10'(Y_MAX) : 10'(y_ext + STEP);
        end else if (level[0] && !level[1]) begin
            next_y = (y_ext < Y_MIN + STEP) ? 10'(Y_MIN) : 10'(y_ext - STEP);
        end
        next_score = (score == 14'd9999) ? score : score + 14'd1;
    end

    always_ff @(posedge ClkPort or posedge BtnC) begin
        if (BtnC) begin
            state   <= StIdle;
            pos_x   <= 10'(X_START);
            pos_y   <= 10'(Y_START);
            score   <= '0;
            lives   <= 2'd3;
            hit_cnt <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (|press) state <= StPlay;
                end
                StPlay: begin
                    if (bus.frame_tick) begin
                        if (bus.collision) begin
                            lives   <= lives - 2'd1;
                            pos_x   <= 10'(X_START);
                            pos_y   <= 10'(Y_START);
                            hit_cnt <= '0;
                            state   <= (lives == 2'd1) ? StOver : StHit;
                        end else begin
                            pos_x <= next_x;
                            pos_y <= next_y;
                            score <= next_score;
                        end
                    end
                end
                StHit: begin
                    if (bus.frame_tick) begin
                        if (hit_cnt == 16'(HIT_FRAMES - 1)) begin
                            hit_cnt <= '0;
                            state   <= StPlay;
                        end else begin
                            hit_cnt <= hit_cnt + 16'd1;
                        end
                    end
                end
                StOver: begin
                    if (|press) begin
                        state <= StIdle;
                        score <= '0;
                        lives <= 2'd3;
                        pos_x <= 10'(X_START);
                        pos_y <= 10'(Y_START);
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign bus.state = state;
    assign bus.pos_x = pos_x;
    assign bus.pos_y = pos_y;
    assign bus.score = score;
    assign bus.lives = lives;

endmodule

// File: doc/game_ctrl.md
GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- DEBOUNCE_CYCLES, 250000, consecutive stable cycles before a debounced button level changes.
- STEP, 4, pixels moved per frame per held direction.
- X_MIN, 144, leftmost legal pos_x.
- X_MAX, 783, rightmost legal pos_x.
- Y_MIN, 35, topmost legal pos_y.
- Y_MAX, 514, bottommost legal pos_y.
- X_START, 464, pos_x after reset or respawn.
- Y_START, 275, pos_y after reset or respawn.
- HIT_FRAMES, 60, frames spent in HIT.
REQ-002 Ports (name, direction, width, meaning), one per line:
- ClkPort, in, 1, sole clock; all logic on the rising edge.
- BtnC, in, 1, reset; asynchronous, active-high.
- BtnU/BtnD/BtnL/BtnR, in, 1 each, raw asynchronous push-buttons.
- frame_tick, in, 1, one-cycle pulse per VGA frame, synchronous to ClkPort.
- collision, in, 1, level; sampled only on frame_tick.
- state, out, 2, 0=IDLE, 1=PLAY, 2=HIT, 3=OVER.
- pos_x, out, 10, player x coordinate.
- pos_y, out, 10, player y coordinate.
- score, out, 14, binary score, 0..9999.
- lives, out, 2, remaining lives.

Function
REQ-003 Each button SHALL pass through a two-flop synchronizer and then a debounce counter.
REQ-004 A debounced level SHALL change only after the synchronized value has differed from it for DEBOUNCE_CYCLES consecutive cycles; any mismatch-free cycle clears the counter.
REQ-005 A raw edge held stable SHALL reach the debounced level exactly DEBOUNCE_CYCLES+2 rising edges after it is first sampled.
REQ-006 A press pulse SHALL assert for one cycle on each debounced rising edge; releases produce no pulse.
REQ-007 IDLE: a press pulse on any button -> PLAY on the next edge; frame_tick is ignored.
REQ-008 PLAY, on each frame_tick, movement:
- pos_x += STEP while R is held; pos_x -= STEP while L is held.
- pos_y += STEP while D is held; pos_y -= STEP while U is held.
- L+R held together -> no x change; U+D held together -> no y change.
REQ-009 Results SHALL clamp to [X_MIN, X_MAX] and [Y_MIN, Y_MAX]; no wrap-around and no 10-bit underflow.
REQ-010 PLAY, on each frame_tick without collision: score += 1, saturating at 9999.
REQ-011 PLAY, frame_tick with collision=1 (collision wins over movement and scoring):
- lives -= 1; pos -> (X_START, Y_START); score held.
- next state HIT if lives > 0 after the decrement, else OVER.
REQ-012 HIT: a frame counter SHALL count frame_ticks; on the HIT_FRAMES-th frame_tick -> PLAY.
- In HIT, buttons, collision, pos and score are frozen.
REQ-013 OVER: outputs hold; a press pulse -> IDLE on the next edge, with score=0, lives=3, pos=(X_START, Y_START).
REQ-014 If a press pulse and frame_tick coincide in IDLE: transition to PLAY only; no movement or score that cycle.
REQ-015 All outputs SHALL be registered; the state/pos/score/lives update is visible one cycle after the triggering frame_tick or pulse.

Reset
REQ-016 BtnC=1 SHALL immediately and asynchronously force:
- state=IDLE, pos=(X_START, Y_START), score=0, lives=3.
- All debounce counters, synchronizers, debounced levels and the HIT counter = 0.
REQ-017 Release of BtnC SHALL be sampled synchronously; no press pulse SHALL be generated by a button held through reset until its debounce completes.
REQ-018 Reset asserted mid-HIT or mid-debounce SHALL abort the operation with no residual pulse after release.

Verification (DEBOUNCE_CYCLES=4, HIT_FRAMES=2)
REQ-019 BtnU glitch high 3 cycles, then BtnU held 10 cycles -> no pulse from the glitch; exactly one pulse, 6 edges after the stable high; state IDLE->PLAY.
REQ-020 PLAY, BtnR held, 3 frame_ticks -> pos_x 464->476, pos_y=275, score=3; then BtnL+BtnR held, 1 frame_tick -> pos_x=476, score=4.
REQ-021 PLAY, pos_x=782 with BtnR held, frame_tick -> pos_x=783; pos_y=36 with BtnU held, frame_tick -> pos_y=35.
REQ-022 PLAY, lives=3, frame_tick with collision=1 while BtnR held -> lives=2, pos=(464,275), state=HIT; 2 frame_ticks -> PLAY; score unchanged.
REQ-023 lives=1, collision frame_tick -> state=OVER, lives=0; BtnD press -> IDLE, score=0, lives=3.
REQ-024 score=9999, PLAY frame_tick -> score stays 9999; BtnC pulsed mid-HIT -> outputs at reset values within the same cycle, no spurious pulse after release.
